rlg_mix_core: RTL and testbench
===============================

// Module: rlg_mix_core
// PURPOSE
//  Iterative, parametrised reversible-logic mixing core for the AES front end.
//  Each round applies three stages to a block of 8 lanes: a Fredkin/Feynman gate layer (G),
//  an SCL gate layer (S) and a one-lane rotation.
//  The core runs a programmable number of rounds in forward mode, or exactly undoes them in
//  inverse mode, and uses valid/ready handshakes on both sides.
//  It sits between the input block buffer and the AES round datapath.
// PARAMETERS
//  LANE_W  16  lane width in bits; block width BLK_W = 8*LANE_W
//  ROUNDS  4   rounds per block; must be >=1 (elaboration error otherwise)
// PORTS
//  clk        in   1       single clock, all state updates on rising edge
//  rst        in   1       synchronous active-high reset
//  in_valid   in   1       input block offered
//  in_ready   out  1       core idle, can accept a block
//  in_data    in   BLK_W   input block; lane k = bits [k*LANE_W +: LANE_W]
//  in_mode    in   1       0 = forward, 1 = inverse; sampled only on accept
//  out_valid  out  1       result available
//  out_ready  in   1       consumer takes the result
//  out_data   out  BLK_W   result block
//  busy       out  1       high in RUN or DONE
// BEHAVIOUR
//  Gate layer G (bitwise per lane, L0..L7 = lanes):
//   Fredkin(L0,L1,L2): L0'=L0; L1'=~L0&L1|L0&L2; L2'=~L0&L2|L0&L1. Fredkin(L5,L6,L7) likewise.
//   Feynman(L3,L4): L3'=L3; L4'=L3^L4.
//  Gate layer S: L3'=(L0&(L1|L2))^L3; L7'=(L4&(L5|L6))^L7; all other lanes pass through.
//  ROT_L: out lane (k+1)%8 = in lane k (circular left shift by LANE_W bits). ROT_R is its inverse.
//  Forward round: x -> ROT_L(S(G(x))). Inverse round: y -> G(S(ROT_R(y))).
//  G and S are each self-inverse, so inverse mode with the same ROUNDS restores the original block.
//  FSM states IDLE, RUN, DONE:
//   IDLE: in_ready=1. On in_valid&in_ready: load in_data into the state register, latch
//         in_mode, clear the round counter, go to RUN. No round is applied on this edge.
//   RUN: every edge applies one round (per the latched mode) and increments the counter.
//        On the edge that applies round ROUNDS, go to DONE.
//   DONE: out_valid=1 and out_data = state register, held stable until out_ready.
//         On out_valid&out_ready, go to IDLE.
//  Latency: the accept edge is E0; out_valid is visible after edge E_ROUNDS.
//   Minimum spacing between accepts is ROUNDS+2 cycles. Blocks are never overlapped.
//  in_ready=(state==IDLE); busy=~in_ready. in_valid outside IDLE is ignored and
//   in_data/in_mode are not sampled.
//  out_ready outside DONE has no effect. out_ready held high in DONE retires the block
//   after one cycle.
//  Round counter width is $clog2(ROUNDS+1). It cannot wrap because it stops at ROUNDS.
//  Reset (any state, including mid-RUN or DONE with a pending result): state=IDLE,
//   in_ready=1, out_valid=0, busy=0, out_data=0, counter=0, latched mode=0.
//   The partial block is discarded.
//  rst takes priority over any handshake in the same cycle.
// TESTING
//  T1 ROUNDS=1, LANE_W=16, fwd, in_data=all-ones -> out_data=FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF,
//     out_valid one edge after accept.
//  T2 ROUNDS=1, inv, in_data=FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF -> out_data=all-ones;
//     in_data=0 in either mode -> 0.
//  T3 ROUNDS=4, 100 random blocks: fwd then inv -> exact original block; out_valid exactly
//     4 edges after each accept.
//  T4 Hold out_ready=0 for 10 cycles in DONE -> out_data and out_valid stable, in_ready=0;
//     in_valid pulses with other data are ignored.
//  T5 Assert rst for one cycle at RUN round 2 -> next cycle in_ready=1, out_valid=0,
//     out_data=0; a new block then completes correctly.
//  T6 LANE_W=8, ROUNDS=3: random round-trip fwd/inv -> identity; in_mode toggled during RUN
//     -> no effect on the result.

Source files
------------

// File: rtl/rlg_mix_core.sv
// rtl/rlg_mix_core.sv - iterative reversible-logic mixing core (G layer, S layer, lane rotation)
// Runs ROUNDS forward rounds or exactly undoes them in inverse mode, valid/ready on both sides.
module rlg_mix_core #(
  parameter int LANE_W = 16,
  parameter int ROUNDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*LANE_W-1:0]   in_data,
  input  logic                  in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*LANE_W-1:0]   out_data,
  output logic                  busy
);

  localparam int BLK_W = 8 * LANE_W;
  localparam int CW    = $clog2(ROUNDS + 1);
  localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

  if (ROUNDS < 1) begin : g_bad_rounds
    $error("rlg_mix_core: ROUNDS must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state, state_d;
  logic [BLK_W-1:0]  blk;
  logic [CW-1:0]     cnt;
  logic              mode;

  // Fredkin on (L0,L1,L2) and (L5,L6,L7), Feynman on (L3,L4); self-inverse.
  function automatic logic [BLK_W-1:0] gate_g(input logic [BLK_W-1:0] x);
    logic [7:0][LANE_W-1:0] l, r;
    l = x;
    r = l;
    r[1] = (~l[0] & l[1]) | (l[0] & l[2]);
    r[2] = (~l[0] & l[2]) | (l[0] & l[1]);
    r[4] = l[3] ^ l[4];
    r[6] = (~l[5] & l[6]) | (l[5] & l[7]);
    r[7] = (~l[5] & l[7]) | (l[5] & l[6]);
    return r;
  endfunction

  // Control lanes are untouched, so XOR-ing the same term again undoes it.
  function automatic logic [BLK_W-1:0] gate_s(input logic [BLK_W-1:0] x);
    logic [7:0][LANE_W-1:0] l, r;
    l = x;
    r = l;
    r[3] = (l[0] & (l[1] | l[2])) ^ l[3];
    r[7] = (l[4] & (l[5] | l[6])) ^ l[7];
    return r;
  endfunction

  function automatic logic [BLK_W-1:0] rot_l(input logic [BLK_W-1:0] x);
    return {x[7*LANE_W-1:0], x[BLK_W-1:7*LANE_W]};
  endfunction

  function automatic logic [BLK_W-1:0] rot_r(input logic [BLK_W-1:0] x);
    return {x[LANE_W-1:0], x[BLK_W-1:LANE_W]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (in_valid)       state_d = S_RUN;
      S_RUN:   if (cnt == LAST)    state_d = S_DONE;
      S_DONE:  if (out_ready)      state_d = S_IDLE;
      default:                     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
    busy      = (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk  <= '0;
      cnt  <= '0;
      mode <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            blk  <= in_data;
            mode <= in_mode;
            cnt  <= '0;
          end
        end
        S_RUN: begin
          blk <= mode ? gate_g(gate_s(rot_r(blk))) : rot_l(gate_s(gate_g(blk)));
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_data = blk;

endmodule

// File: tb/tb_rlg_mix_core.sv
// tb/tb_rlg_mix_core.sv - randomized self-checking bench for rlg_mix_core
// Three instances: (16,1), (16,4), (8,3), checked against a lane-array reference model.
module tb_rlg_mix_core;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         vld[3];
  logic         md[3];
  logic         ordy[3];
  logic [127:0] din[3];
  logic         irdy[3];
  logic         ov[3];
  logic         bsy[3];
  logic [127:0] dout[3];

  logic [127:0] q0, q1;
  logic [63:0]  q2;
  logic         ir0, ir1, ir2, ov0, ov1, ov2, b0, b1, b2;

  int lw[3] = '{16, 16, 8};
  int rn[3] = '{1, 4, 3};

  int checks = 0;
  int failures = 0;

  rlg_mix_core #(.LANE_W(16), .ROUNDS(1)) dut_r1 (
    .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(ir0), .in_data(din[0]),
    .in_mode(md[0]), .out_valid(ov0), .out_ready(ordy[0]), .out_data(q0), .busy(b0));
  rlg_mix_core #(.LANE_W(16), .ROUNDS(4)) dut_r4 (
    .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(ir1), .in_data(din[1]),
    .in_mode(md[1]), .out_valid(ov1), .out_ready(ordy[1]), .out_data(q1), .busy(b1));
  rlg_mix_core #(.LANE_W(8), .ROUNDS(3)) dut_l8 (
    .clk(clk), .rst(rst), .in_valid(vld[2]), .in_ready(ir2), .in_data(din[2][63:0]),
    .in_mode(md[2]), .out_valid(ov2), .out_ready(ordy[2]), .out_data(q2), .busy(b2));

  always_comb begin
    dout[0] = q0;  dout[1] = q1;  dout[2] = {64'b0, q2};
    irdy[0] = ir0; irdy[1] = ir1; irdy[2] = ir2;
    ov[0]   = ov0; ov[1]   = ov1; ov[2]   = ov2;
    bsy[0]  = b0;  bsy[1]  = b1;  bsy[2]  = b2;
  end

  typedef logic [7:0][15:0] lanes_t;

  function automatic lanes_t m_g(input lanes_t a);
    lanes_t b = a;
    b[1] = (~a[0] & a[1]) | (a[0] & a[2]);
    b[2] = (~a[0] & a[2]) | (a[0] & a[1]);
    b[4] = a[3] ^ a[4];
    b[6] = (~a[5] & a[6]) | (a[5] & a[7]);
    b[7] = (~a[5] & a[7]) | (a[5] & a[6]);
    return b;
  endfunction

  function automatic lanes_t m_s(input lanes_t a);
    lanes_t b = a;
    b[3] = (a[0] & (a[1] | a[2])) ^ a[3];
    b[7] = (a[4] & (a[5] | a[6])) ^ a[7];
    return b;
  endfunction

  function automatic lanes_t m_rot(input lanes_t a, input bit right);
    lanes_t b;
    for (int k = 0; k < 8; k++) begin
      if (right) b[k] = a[(k + 1) % 8];
      else       b[(k + 1) % 8] = a[k];
    end
    return b;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] x, input int w, input int r, input bit inv);
    lanes_t l;
    logic [15:0] m;
    logic [127:0] y;
    m = 16'((32'h1 << w) - 1);
    for (int k = 0; k < 8; k++) l[k] = 16'(x >> (k * w)) & m;
    for (int n = 0; n < r; n++) begin
      if (!inv) l = m_rot(m_s(m_g(l)), 1'b0);
      else      l = m_g(m_s(m_rot(l, 1'b1)));
      for (int k = 0; k < 8; k++) l[k] = l[k] & m;
    end
    y = '0;
    for (int k = 0; k < 8; k++) y = y | (128'(l[k]) << (k * w));
    return y;
  endfunction

  function automatic logic [127:0] rnd_blk(input int i);
    logic [127:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    return d & ((128'h1 << (8 * lw[i])) - 128'h1);
  endfunction

  // One full transaction; out_ready is held high throughout, optional noise on in_valid/in_mode during RUN.
  task automatic xfer(input int i, input logic [127:0] d, input bit m, input bit noise,
                      output logic [127:0] q, output int lat);
    @(negedge clk);
    checks++;
    if (irdy[i] !== 1'b1) begin
      failures++; $display("FAIL in_ready_before_accept dut=%0d got=%b exp=1", i, irdy[i]);
    end
    vld[i] = 1'b1; din[i] = d; md[i] = m; ordy[i] = 1'b1;
    @(negedge clk);
    vld[i] = 1'b0;
    lat = 0;
    while (ov[i] !== 1'b1 && lat < 64) begin
      if (noise) begin
        md[i] = ~md[i]; din[i] = rnd_blk(i); vld[i] = $urandom_range(0, 1);
      end
      @(negedge clk);
      lat++;
    end
    vld[i] = 1'b0;
    checks++;
    if (lat >= 64) begin
      failures++; $display("FAIL out_valid_timeout dut=%0d got=%0d exp<64", i, lat);
    end
    q = dout[i];
    @(negedge clk);
    ordy[i] = 1'b0;
    checks++;
    if (ov[i] !== 1'b0 || irdy[i] !== 1'b1) begin
      failures++; $display("FAIL retire dut=%0d got ov=%b ir=%b exp ov=0 ir=1", i, ov[i], irdy[i]);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (irdy[i] !== 1'b1 || ov[i] !== 1'b0 || bsy[i] !== 1'b0 || dout[i] !== 128'h0) begin
        failures++;
        $display("FAIL reset_state dut=%0d got ir=%b ov=%b busy=%b data=%h exp 1/0/0/0",
                 i, irdy[i], ov[i], bsy[i], dout[i]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_single_round;
    logic [127:0] q;
    int lat;
    xfer(0, {128{1'b1}}, 1'b0, 1'b0, q, lat);
    checks++;
    if (q !== 128'hFFFFFFFF_00000000_FFFFFFFF_FFFFFFFF) begin
      failures++; $display("FAIL t1_fwd_ones got=%h exp=FFFFFFFF00000000FFFFFFFFFFFFFFFF", q);
    end
    checks++;
    if (lat !== 1) begin
      failures++; $display("FAIL t1_latency got=%0d exp=1", lat);
    end
    xfer(0, 128'hFFFFFFFF_00000000_FFFFFFFF_FFFFFFFF, 1'b1, 1'b0, q, lat);
    checks++;
    if (q !== {128{1'b1}}) begin
      failures++; $display("FAIL t2_inv_const got=%h exp=all-ones", q);
    end
    for (int m = 0; m < 2; m++) begin
      xfer(0, 128'h0, m[0], 1'b0, q, lat);
      checks++;
      if (q !== 128'h0) begin
        failures++; $display("FAIL t2_zero mode=%0d got=%h exp=0", m, q);
      end
    end
  endtask

  task automatic test_round_trip(input int i, input int n, input bit noise);
    logic [127:0] d, f, b, e;
    int lat;
    for (int t = 0; t < n; t++) begin
      d = rnd_blk(i);
      e = model(d, lw[i], rn[i], 1'b0);
      xfer(i, d, 1'b0, noise, f, lat);
      checks++;
      if (f !== e) begin
        failures++; $display("FAIL fwd_model dut=%0d got=%h exp=%h", i, f, e);
      end
      checks++;
      if (lat !== rn[i]) begin
        failures++; $display("FAIL latency dut=%0d got=%0d exp=%0d", i, lat, rn[i]);
      end
      xfer(i, f, 1'b1, noise, b, lat);
      checks++;
      if (b !== d) begin
        failures++; $display("FAIL inv_restore dut=%0d got=%h exp=%h", i, b, d);
      end
    end
  endtask

  task automatic test_hold_done;
    logic [127:0] d, e;
    int n;
    d = rnd_blk(1);
    e = model(d, 16, 4, 1'b0);
    @(negedge clk);
    vld[1] = 1'b1; din[1] = d; md[1] = 1'b0; ordy[1] = 1'b0;
    @(negedge clk);
    vld[1] = 1'b0;
    n = 0;
    while (ov[1] !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    for (int c = 0; c < 10; c++) begin
      vld[1] = $urandom_range(0, 1); din[1] = rnd_blk(1); md[1] = $urandom_range(0, 1);
      @(negedge clk);
      checks++;
      if (dout[1] !== e || ov[1] !== 1'b1 || irdy[1] !== 1'b0 || bsy[1] !== 1'b1) begin
        failures++;
        $display("FAIL hold_done cyc=%0d got data=%h ov=%b ir=%b exp data=%h ov=1 ir=0",
                 c, dout[1], ov[1], irdy[1], e);
      end
    end
    vld[1] = 1'b0; ordy[1] = 1'b1;
    @(negedge clk);
    ordy[1] = 1'b0;
    checks++;
    if (ov[1] !== 1'b0 || irdy[1] !== 1'b1) begin
      failures++; $display("FAIL hold_release got ov=%b ir=%b exp ov=0 ir=1", ov[1], irdy[1]);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [127:0] d, q;
    int lat;
    @(negedge clk);
    vld[1] = 1'b1; din[1] = rnd_blk(1); md[1] = 1'b0; ordy[1] = 1'b0;
    @(negedge clk);
    vld[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (irdy[1] !== 1'b1 || ov[1] !== 1'b0 || dout[1] !== 128'h0 || bsy[1] !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_run got ir=%b ov=%b busy=%b data=%h exp 1/0/0/0",
               irdy[1], ov[1], bsy[1], dout[1]);
    end
    d = rnd_blk(1);
    xfer(1, d, 1'b0, 1'b0, q, lat);
    checks++;
    if (q !== model(d, 16, 4, 1'b0)) begin
      failures++; $display("FAIL after_reset_block got=%h exp=%h", q, model(d, 16, 4, 1'b0));
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0; md[i] = 1'b0; ordy[i] = 1'b0; din[i] = '0;
    end
    test_reset;
    test_single_round;
    test_round_trip(1, 100, 1'b0);
    test_hold_done;
    test_reset_mid_run;
    test_round_trip(2, 40, 1'b1);
    test_round_trip(0, 10, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
